// File: rtl/iob_axistream_out_arb_if.sv
// Stream bundle for the output arbiter: N_REQ requester streams in, one merged stream out.
// master = arbiter side, slave = requesters plus downstream sink.
interface iob_axistream_out_arb_if #(
  parameter int TDATA_W = 8,
  parameter int N_REQ   = 2
);
  logic [N_REQ*TDATA_W-1:0] s_tdata_i;
  logic [N_REQ-1:0]         s_tvalid_i;
  logic [N_REQ-1:0]         s_tlast_i;
  logic [N_REQ-1:0]         s_tready_o;
  logic [TDATA_W-1:0]       m_tdata_o;
  logic                     m_tvalid_o;
  logic                     m_tlast_o;
  logic                     m_tready_i;

  modport master (
    input  s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
    output s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o
  );

  modport slave (
    output s_tdata_i, s_tvalid_i, s_tlast_i, m_tready_i,
    input  s_tready_o, m_tdata_o, m_tvalid_o, m_tlast_o
  );
endinterface

// File: rtl/iob_axistream_out_arb.sv
// Packet-locked AXI-Stream arbiter with one registered output stage.
// Fixed priority by default; define IOB_AXISTREAM_OUT_ARB_RR_EN for round-robin.
module iob_axistream_out_arb #(
  parameter int  TDATA_W = 8,
  parameter int  N_REQ   = 2,
  localparam int GRANT_W = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  iob_axistream_out_arb_if.master bus,
  output logic [GRANT_W-1:0]      grant_o,
  output logic                    busy_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               r_state;
  logic [GRANT_W-1:0]   r_grant;
  logic                 r_busy;
  logic [TDATA_W-1:0]   r_m_tdata;
  logic                 r_m_tvalid;
  logic                 r_m_tlast;

  logic [GRANT_W-1:0]   w_winner;
  logic [TDATA_W-1:0]   w_sel_data;
  logic                 w_any_req;
  logic                 w_room;
  logic                 w_accept;
  logic                 w_last;

  assign w_any_req = |bus.s_tvalid_i;
  assign w_room    = ~r_m_tvalid | bus.m_tready_i;
  // A stalled clock must not let a requester believe its beat was taken.
  assign w_accept  = (r_state == LOCKED) & bus.s_tvalid_i[r_grant] & w_room & cke_i;
  assign w_last    = bus.s_tlast_i[r_grant];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    bus.s_tready_o = '0;
    if (r_state == LOCKED && cke_i) bus.s_tready_o[r_grant] = w_room;
  end

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant == GRANT_W'(k)) w_sel_data = bus.s_tdata_i[k*TDATA_W +: TDATA_W];
    end
  end

`ifdef IOB_AXISTREAM_OUT_ARB_RR_EN
  localparam int SUM_W = GRANT_W + 1;

  logic [GRANT_W-1:0] r_ptr;
  logic [SUM_W-1:0]   w_slot;
  logic               w_found;

  function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] g);
    return (g == GRANT_W'(N_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // Search starts at r_ptr and wraps modulo N_REQ (N_REQ need not be a power of two).
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_slot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_slot = {1'b0, r_ptr} + SUM_W'(i);
      if (w_slot >= SUM_W'(N_REQ)) w_slot = w_slot - SUM_W'(N_REQ);
      if (!w_found && bus.s_tvalid_i[w_slot[GRANT_W-1:0]]) begin
        w_winner = w_slot[GRANT_W-1:0];
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ptr <= '0;
    end else if (cke_i) begin
      if (rst_i)                  r_ptr <= '0;
      else if (w_accept && w_last) r_ptr <= wrap_inc(r_grant);
    end
  end
`else
  always_comb begin
    w_winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.s_tvalid_i[i]) w_winner = GRANT_W'(i);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_state <= IDLE;
        r_grant <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (en_i && w_any_req) begin
              r_grant <= w_winner;
              r_state <= LOCKED;
              r_busy  <= 1'b1;
            end
          end
          LOCKED: begin
            if (w_accept && w_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output stage drains on its own once the FSM has released the lock.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_m_tdata  <= '0;
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end else if (w_accept) begin
        r_m_tdata  <= w_sel_data;
        r_m_tvalid <= 1'b1;
        r_m_tlast  <= w_last;
      end else if (bus.m_tready_i) begin
        r_m_tvalid <= 1'b0;
        r_m_tlast  <= 1'b0;
      end
    end
  end

  assign bus.m_tdata_o  = r_m_tdata;
  assign bus.m_tvalid_o = r_m_tvalid;
  assign bus.m_tlast_o  = r_m_tlast;
  assign grant_o        = r_grant;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_iob_axistream_out_arb.sv
// Self-checking bench for iob_axistream_out_arb (N_REQ=2, TDATA_W=8), both arbitration builds.
// Expected beats go into a scoreboard queue in the order the arbitration rule dictates.
module tb_iob_axistream_out_arb;
  localparam int TDATA_W = 8;
  localparam int N_REQ   = 2;
  localparam int GRANT_W = 1;

  logic               clk_i = 1'b0;
  logic               arst_n_i, cke_i, rst_i, en_i;
  logic [GRANT_W-1:0] grant_o;
  logic               busy_o;

  iob_axistream_out_arb_if #(.TDATA_W(TDATA_W), .N_REQ(N_REQ)) bus ();

  iob_axistream_out_arb #(.TDATA_W(TDATA_W), .N_REQ(N_REQ)) dut (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .bus      (bus),
    .grant_o  (grant_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       busy;
    logic [1:0] s_tready;
    logic       m_tvalid;
    logic [7:0] m_tdata;
    logic       m_tlast;
    logic       grant;
  } vec_t;

  beat_t            src_q [N_REQ][$];
  beat_t            sb [$];
  logic [N_REQ-1:0] fire, src_gate;
  logic             rdy_toggle, prev_stall, prev_last, chk_gap;
  logic [7:0]       prev_data;
  int               n_checks = 0, n_errors = 0, cyc = 0, prev_out_cyc = -1;
  vec_t             vt [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit src_empty();
    for (int k = 0; k < N_REQ; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_src();
    for (int k = 0; k < N_REQ; k++) begin
      if (src_q[k].size() != 0 && src_gate[k]) begin
        bus.s_tvalid_i[k]                    = 1'b1;
        bus.s_tdata_i[k*TDATA_W +: TDATA_W] = src_q[k][0].data;
        bus.s_tlast_i[k]                     = src_q[k][0].last;
      end else begin
        bus.s_tvalid_i[k]                    = 1'b0;
        bus.s_tdata_i[k*TDATA_W +: TDATA_W] = '0;
        bus.s_tlast_i[k]                     = 1'b0;
      end
    end
  endtask

  task automatic load_src(input int k, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) src_q[k].push_back({base + 8'(i), i == n - 1});
  endtask

  task automatic expect_pkt(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) sb.push_back({base + 8'(i), i == n - 1});
  endtask

  // Observe one cycle at the falling edge: hold rule, ready rule, scoreboard, handshakes.
  task automatic sample();
    beat_t e;
    logic  exp_rdy;
    @(negedge clk_i);
    if (prev_stall) begin
      check("hold_valid", bus.m_tvalid_o, 1'b1);
      check("hold_data", bus.m_tdata_o, prev_data);
      check("hold_last", bus.m_tlast_o, prev_last);
    end
    for (int k = 0; k < N_REQ; k++) begin
      exp_rdy = busy_o && (k == int'(grant_o)) && (!bus.m_tvalid_o || bus.m_tready_i);
      check("s_tready", bus.s_tready_o[k], exp_rdy);
    end
    if (bus.m_tvalid_o && bus.m_tready_i) begin
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_tdata", bus.m_tdata_o, e.data);
        check("m_tlast", bus.m_tlast_o, e.last);
      end
      if (chk_gap && prev_out_cyc >= 0) check("beat_gap", cyc - prev_out_cyc, 2);
      prev_out_cyc = cyc;
    end
    prev_stall = bus.m_tvalid_o && !bus.m_tready_i;
    prev_data  = bus.m_tdata_o;
    prev_last  = bus.m_tlast_o;
    fire       = bus.s_tvalid_i & bus.s_tready_o;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < N_REQ; k++) if (fire[k]) void'(src_q[k].pop_front());
    if (rdy_toggle) bus.m_tready_i = ~bus.m_tready_i;
    drive_src();
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while ((sb.size() != 0 || !src_empty()) && c < budget) begin
      tick();
      c++;
    end
    check("drain_in_budget", c < budget, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n_i = 1'b0; cke_i = 1'b1; rst_i = 1'b0; en_i = 1'b1;
    bus.m_tready_i = 1'b1; rdy_toggle = 1'b0; src_gate = '1; chk_gap = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; fire = '0;
    drive_src();

    // Reset state while arst_n_i is held low.
    #3;
    check("rst_busy", busy_o, 1'b0);
    check("rst_grant", grant_o, 1'b0);
    check("rst_m_tvalid", bus.m_tvalid_o, 1'b0);
    check("rst_m_tdata", bus.m_tdata_o, 8'h00);
    check("rst_m_tlast", bus.m_tlast_o, 1'b0);
    check("rst_s_tready", bus.s_tready_o, 2'b00);
    @(posedge clk_i); @(posedge clk_i); #1;
    arst_n_i = 1'b1;

    // Single packet, cycle by cycle: 0x11, 0x22, 0x33(last) from requester 0.
    vt[0] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 8'h11, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 8'h22, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 8'h33, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    src_q[0].push_back({8'h11, 1'b0}); sb.push_back({8'h11, 1'b0});
    src_q[0].push_back({8'h22, 1'b0}); sb.push_back({8'h22, 1'b0});
    src_q[0].push_back({8'h33, 1'b1}); sb.push_back({8'h33, 1'b1});
    drive_src();
    for (int i = 0; i < 6; i++) begin
      en_i = vt[i].en;
      bus.m_tready_i = vt[i].rdy;
      sample();
      check($sformatf("vec%0d_busy", i), busy_o, vt[i].busy);
      check($sformatf("vec%0d_s_tready", i), bus.s_tready_o, vt[i].s_tready);
      check($sformatf("vec%0d_m_tvalid", i), bus.m_tvalid_o, vt[i].m_tvalid);
      check($sformatf("vec%0d_grant", i), grant_o, vt[i].grant);
      if (vt[i].m_tvalid) begin
        check($sformatf("vec%0d_m_tdata", i), bus.m_tdata_o, vt[i].m_tdata);
        check($sformatf("vec%0d_m_tlast", i), bus.m_tlast_o, vt[i].m_tlast);
      end
      advance();
    end

    // Soft reset mid-packet from requester 1: clears stage, grant and pointer.
    load_src(1, 4, 8'hC0);
    expect_pkt(2, 8'hC0);
    sb[1].last = 1'b0;
    drive_src();
    tick(); tick(); tick();
    rst_i = 1'b1;
    src_q[1].delete();
    drive_src();
    tick();
    rst_i = 1'b0;
    check("srst_busy", busy_o, 1'b0);
    check("srst_grant", grant_o, 1'b0);
    check("srst_m_tvalid", bus.m_tvalid_o, 1'b0);
    check("srst_m_tdata", bus.m_tdata_o, 8'h00);
    check("srst_sb_empty", sb.size(), 0);
    sb.delete();

    // Contention: two 2-beat packets queued on each requester.
    load_src(0, 2, 8'hA0); load_src(0, 2, 8'hA2);
    load_src(1, 2, 8'hB0); load_src(1, 2, 8'hB2);
`ifdef IOB_AXISTREAM_OUT_ARB_RR_EN
    expect_pkt(2, 8'hA0); expect_pkt(2, 8'hB0); expect_pkt(2, 8'hA2); expect_pkt(2, 8'hB2);
`else
    expect_pkt(2, 8'hA0); expect_pkt(2, 8'hA2); expect_pkt(2, 8'hB0); expect_pkt(2, 8'hB2);
`endif
    drive_src();
    run_drain(60);

    // Backpressure: m_tready_i toggles every cycle during a 4-beat packet.
    load_src(0, 4, 8'hD0);
    expect_pkt(4, 8'hD0);
    drive_src();
    rdy_toggle = 1'b1;
    run_drain(60);
    rdy_toggle = 1'b0;
    bus.m_tready_i = 1'b1;

    // Granted requester drops valid mid-packet while requester 1 waits: lock is kept.
    load_src(0, 4, 8'hE0);
    expect_pkt(4, 8'hE0);
    expect_pkt(1, 8'hF0);
    drive_src();
    tick(); tick();
    load_src(1, 1, 8'hF0);
    tick();
    src_gate[0] = 1'b0;
    drive_src();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drop_busy", busy_o, 1'b1);
      check("drop_grant", grant_o, 1'b0);
    end
    src_gate[0] = 1'b1;
    drive_src();
    run_drain(60);

    // Enable drops after the first beat: packet completes, then no new grant.
    load_src(0, 4, 8'h50);
    expect_pkt(4, 8'h50);
    drive_src();
    tick(); tick();
    en_i = 1'b0;
    run_drain(60);
    check("en_off_busy", busy_o, 1'b0);
    load_src(1, 1, 8'h60);
    drive_src();
    for (int i = 0; i < 4; i++) tick();
    check("en_off_no_grant", busy_o, 1'b0);
    check("en_off_pending", src_q[1].size(), 1);
    en_i = 1'b1;
    expect_pkt(1, 8'h60);
    run_drain(30);
    check("en_on_grant", grant_o, 1'b1);

    // Single-beat packets back to back: one beat every 2 cycles.
    load_src(0, 1, 8'h70); load_src(0, 1, 8'h71);
    load_src(1, 1, 8'h80); load_src(1, 1, 8'h81);
`ifdef IOB_AXISTREAM_OUT_ARB_RR_EN
    expect_pkt(1, 8'h70); expect_pkt(1, 8'h80); expect_pkt(1, 8'h71); expect_pkt(1, 8'h81);
`else
    expect_pkt(1, 8'h70); expect_pkt(1, 8'h71); expect_pkt(1, 8'h80); expect_pkt(1, 8'h81);
`endif
    chk_gap = 1'b1;
    prev_out_cyc = -1;
    drive_src();
    run_drain(40);
    chk_gap = 1'b0;

    // Async reset mid-packet: pointer left at 1 beforehand, must restart from 0.
    load_src(0, 1, 8'h90);
    expect_pkt(1, 8'h90);
    drive_src();
    run_drain(20);
    load_src(1, 4, 8'h20);
    expect_pkt(2, 8'h20);
    sb[1].last = 1'b0;
    drive_src();
    tick(); tick(); tick();
    #2 arst_n_i = 1'b0;
    #1;
    check("arst_m_tvalid", bus.m_tvalid_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_grant", grant_o, 1'b0);
    for (int k = 0; k < N_REQ; k++) src_q[k].delete();
    sb.delete();
    fire = '0;
    prev_stall = 1'b0;
    drive_src();
    #1 arst_n_i = 1'b1;
    load_src(0, 1, 8'h30);
    load_src(1, 1, 8'h40);
    expect_pkt(1, 8'h30);
    expect_pkt(1, 8'h40);
    drive_src();
    run_drain(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
